// File: rtl/pipeline_pkg.sv
// Shared types and default widths for the pipeline stages.
// Stages import this to agree on FSM encodings and the writeback bundle layout.
package pipeline_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int PC_W_DEF   = 32;
    localparam int TMO_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic                  rf_we;
        logic [ADDR_W_DEF-1:0] rf_waddr;
        logic [DATA_W_DEF-1:0] rf_wdata;
    } wb_bundle_t;

endpackage

// File: rtl/memory_stage_wb_reg.sv
// Writeback pipeline register. A bubble clears the write enable and leaves the
// address/data fields holding their last values.
module wb_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_bubble,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [DATA_W-1:0] o_wdata
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_we    <= 1'b0;
            o_waddr <= '0;
            o_wdata <= '0;
        end else if (i_bubble) begin
            o_we    <= 1'b0;
        end else begin
            o_we    <= i_we;
            o_waddr <= i_waddr;
            o_wdata <= i_wdata;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: drives a req/gnt/rvalid data port for loads and stores, stalls
// upstream while an access is outstanding, resolves branches, registers WB.
module memory_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int TMO_W  = TMO_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rf_we_i,
    input  logic              mem_we_i,
    input  logic              mem2rf_i,
    input  logic              branch_i,
    input  logic              check_eq_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [ADDR_W-1:0] rf_waddr_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [PC_W-1:0]   pc_branch_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              stall_o,
    output logic              branch_taken_o,
    output logic [PC_W-1:0]   pc_branch_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic              dmem_err_o
);

    mem_state_t       r_state;
    mem_state_t       w_state_nxt;
    logic [TMO_W-1:0] r_tmo;
    logic             r_err;

    logic             w_mem_op;
    logic             w_rsp_done;
    logic             w_timeout;
    logic             w_stall;
    logic             w_alu_zero;
    logic             w_wb_we;
    logic [DATA_W-1:0] w_wb_wdata;

    assign w_mem_op   = mem_we_i | mem2rf_i;
    assign w_rsp_done = (r_state == RSP) && dmem_rvalid_i;

    // A response arriving on the last waiting cycle wins over the timeout.
    assign w_timeout  = (r_tmo == '1) &&
                        ((r_state == REQ) || ((r_state == RSP) && !dmem_rvalid_i));

    assign w_stall    = !w_timeout &&
                        (((r_state == IDLE) && w_mem_op) ||
                         (r_state == REQ) ||
                         ((r_state == RSP) && !dmem_rvalid_i));

    assign stall_o      = w_stall;
    assign dmem_req_o   = ((r_state == IDLE) && w_mem_op) ||
                          ((r_state == REQ) && !w_timeout);
    assign dmem_we_o    = mem_we_i;
    assign dmem_addr_o  = alu_result_i;
    assign dmem_wdata_o = mem_wdata_i;
    assign dmem_err_o   = r_err;

    assign w_alu_zero     = (alu_result_i == '0);
    assign branch_taken_o = branch_i && !w_stall &&
                            (check_eq_i ? w_alu_zero : !w_alu_zero);
    assign pc_branch_o    = pc_branch_i;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_mem_op) w_state_nxt = dmem_gnt_i ? RSP : REQ;
            REQ: begin
                if (w_timeout)       w_state_nxt = IDLE;
                else if (dmem_gnt_i) w_state_nxt = RSP;
            end
            RSP: if (dmem_rvalid_i || w_timeout) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_tmo   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == IDLE)
                r_tmo <= '0;
            else if (r_state != IDLE)
                r_tmo <= r_tmo + TMO_W'(1);
            if (w_timeout)
                r_err <= 1'b1;
        end
    end

    // Stores and timed-out accesses never write the register file.
    assign w_wb_we    = w_rsp_done ? (rf_we_i & mem2rf_i) : rf_we_i;
    assign w_wb_wdata = (w_rsp_done && mem2rf_i) ? dmem_rdata_i : alu_result_i;

    wb_reg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_wb_reg (
        .clk      (clk),
        .rst_n    (reset),
        .i_bubble (w_stall | w_timeout),
        .i_we     (w_wb_we),
        .i_waddr  (rf_waddr_i),
        .i_wdata  (w_wb_wdata),
        .o_we     (rf_we_o),
        .o_waddr  (rf_waddr_o),
        .o_wdata  (rf_wdata_o)
    );

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: stimulus queues expected memory requests
// and writebacks, a forked monitor pops and compares them as the DUT emits them.
module tb_memory_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int PC_W   = 32;
    localparam int TMO_W  = 4;

    typedef struct {
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } exp_wb_t;

    typedef struct {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } exp_req_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              rf_we_i, mem_we_i, mem2rf_i, branch_i, check_eq_i;
    logic [DATA_W-1:0] mem_wdata_i, alu_result_i, dmem_rdata_i;
    logic [ADDR_W-1:0] rf_waddr_i;
    logic [PC_W-1:0]   pc_branch_i;
    logic              dmem_gnt_i, dmem_rvalid_i;
    logic              dmem_req_o, dmem_we_o, stall_o, branch_taken_o;
    logic [DATA_W-1:0] dmem_addr_o, dmem_wdata_o, rf_wdata_o;
    logic [PC_W-1:0]   pc_branch_o;
    logic              rf_we_o, dmem_err_o;
    logic [ADDR_W-1:0] rf_waddr_o;

    int checks   = 0;
    int failures = 0;
    exp_wb_t  exp_wb[$];
    exp_req_t exp_req[$];

    memory_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .PC_W   (PC_W),
        .TMO_W  (TMO_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rf_we_i        (rf_we_i),
        .mem_we_i       (mem_we_i),
        .mem2rf_i       (mem2rf_i),
        .branch_i       (branch_i),
        .check_eq_i     (check_eq_i),
        .mem_wdata_i    (mem_wdata_i),
        .rf_waddr_i     (rf_waddr_i),
        .alu_result_i   (alu_result_i),
        .pc_branch_i    (pc_branch_i),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_gnt_i     (dmem_gnt_i),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .dmem_rdata_i   (dmem_rdata_i),
        .stall_o        (stall_o),
        .branch_taken_o (branch_taken_o),
        .pc_branch_o    (pc_branch_o),
        .rf_we_o        (rf_we_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_o     (rf_wdata_o),
        .dmem_err_o     (dmem_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rf_we_i = 1'b0; mem_we_i = 1'b0; mem2rf_i = 1'b0; branch_i = 1'b0;
        check_eq_i = 1'b0; mem_wdata_i = '0; rf_waddr_i = '0; alu_result_i = '0;
        pc_branch_i = '0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        exp_wb_t  w;
        exp_req_t r;
        forever begin
            @(negedge clk);
            if (rf_we_o === 1'b1) begin
                if (exp_wb.size() == 0) begin
                    check("wb_unexpected_we", rf_we_o, 1'b0);
                end else begin
                    w = exp_wb.pop_front();
                    check("wb_waddr", rf_waddr_o, w.waddr);
                    check("wb_wdata", rf_wdata_o, w.wdata);
                end
            end
            if (dmem_req_o === 1'b1 && dmem_gnt_i === 1'b1) begin
                if (exp_req.size() == 0) begin
                    check("req_unexpected", dmem_req_o, 1'b0);
                end else begin
                    r = exp_req.pop_front();
                    check("req_we", dmem_we_o, r.we);
                    check("req_addr", dmem_addr_o, r.addr);
                    check("req_wdata", dmem_wdata_o, r.wdata);
                end
            end
        end
    endtask

    task automatic alu_op(input logic [ADDR_W-1:0] waddr, input logic [DATA_W-1:0] res);
        exp_wb_t w;
        rf_we_i = 1'b1; rf_waddr_i = waddr; alu_result_i = res;
        w.waddr = waddr; w.wdata = res;
        exp_wb.push_back(w);
        @(negedge clk);
        check("alu_stall", stall_o, 1'b0);
        check("alu_req", dmem_req_o, 1'b0);
        next_cycle();
        clear_inputs();
    endtask

    // Grant arrives gnt_dly cycles after the request starts; rvalid arrives
    // rsp_dly cycles after the grant cycle. spur adds an rvalid on cycle 0.
    task automatic run_mem(input logic is_store, input logic [DATA_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic [ADDR_W-1:0] waddr,
                           input int gnt_dly, input int rsp_dly,
                           input logic [DATA_W-1:0] rdata, input logic spur,
                           output int stall_n, output int req_n, output int taken_n);
        exp_req_t r;
        exp_wb_t  w;
        stall_n = 0; req_n = 0; taken_n = 0;
        rf_we_i = 1'b1; mem_we_i = is_store; mem2rf_i = !is_store;
        alu_result_i = addr; mem_wdata_i = wdata; rf_waddr_i = waddr;
        r.we = is_store; r.addr = addr; r.wdata = wdata;
        exp_req.push_back(r);
        if (!is_store) begin
            w.waddr = waddr; w.wdata = rdata;
            exp_wb.push_back(w);
        end
        for (int cyc = 0; cyc <= gnt_dly + rsp_dly; cyc++) begin
            dmem_gnt_i    = (cyc == gnt_dly);
            dmem_rvalid_i = (cyc == gnt_dly + rsp_dly) || (spur && cyc == 0);
            dmem_rdata_i  = (cyc == gnt_dly + rsp_dly) ? rdata : 32'hBAD0BAD0;
            @(negedge clk);
            if (stall_o)    stall_n++;
            if (dmem_req_o) req_n++;
            if (stall_o && branch_taken_o) taken_n++;
            next_cycle();
        end
        clear_inputs();
    endtask

    initial begin
        int stall_n, req_n, taken_n;
        clear_inputs();
        fork
            monitor();
        join_none

        // Reset values
        @(negedge clk);
        check("rst_rf_we", rf_we_o, 1'b0);
        check("rst_rf_waddr", rf_waddr_o, '0);
        check("rst_rf_wdata", rf_wdata_o, '0);
        check("rst_err", dmem_err_o, 1'b0);
        check("rst_req", dmem_req_o, 1'b0);
        check("rst_stall", stall_o, 1'b0);
        next_cycle();
        reset = 1'b1;
        next_cycle();

        // Plain ALU writebacks
        alu_op(5'd5, 32'h0000_1234);
        alu_op(5'd31, 32'hFFFF_FFFF);
        @(negedge clk);

        // Branch resolution in IDLE
        next_cycle();
        branch_i = 1'b1; check_eq_i = 1'b1; alu_result_i = 32'd0; pc_branch_i = 32'h0000_0100;
        #1 check("br_eq_zero", branch_taken_o, 1'b1);
        check("br_pc", pc_branch_o, 32'h0000_0100);
        alu_result_i = 32'd7;
        #1 check("br_eq_nonzero", branch_taken_o, 1'b0);
        check_eq_i = 1'b0;
        #1 check("br_ne_nonzero", branch_taken_o, 1'b1);
        alu_result_i = 32'd0; pc_branch_i = 32'h8000_0004;
        #1 check("br_ne_zero", branch_taken_o, 1'b0);
        check("br_pc2", pc_branch_o, 32'h8000_0004);
        branch_i = 1'b0; alu_result_i = 32'd7;
        #1 check("br_not_branch", branch_taken_o, 1'b0);
        clear_inputs();
        next_cycle();

        // Load: grant with a stray rvalid on cycle 0, response two cycles later
        run_mem(1'b0, 32'h40, 32'h0, 5'd3, 0, 2, 32'hDEAD_BEEF, 1'b1, stall_n, req_n, taken_n);
        check("ld_stall_cycles", stall_n, 2);
        check("ld_req_cycles", req_n, 1);
        @(negedge clk);

        // Load at minimum latency: rvalid the cycle after grant
        next_cycle();
        run_mem(1'b0, 32'h84, 32'h0, 5'd9, 0, 1, 32'h0123_4567, 1'b0, stall_n, req_n, taken_n);
        check("ld_min_stall_cycles", stall_n, 1);
        check("ld_min_req_cycles", req_n, 1);
        @(negedge clk);

        // Store with delayed grant; a concurrent branch must stay gated while stalled
        next_cycle();
        branch_i = 1'b1; check_eq_i = 1'b0; pc_branch_i = 32'h200;
        run_mem(1'b1, 32'h100, 32'hCAFE_F00D, 5'd7, 3, 3, 32'h0, 1'b0, stall_n, req_n, taken_n);
        check("st_stall_cycles", stall_n, 6);
        check("st_req_cycles", req_n, 4);
        check("st_branch_gated", taken_n, 0);
        @(negedge clk);
        check("st_no_wb", rf_we_o, 1'b0);

        // Load that is never granted: timeout after 15 waiting cycles
        next_cycle();
        rf_we_i = 1'b1; mem2rf_i = 1'b1; alu_result_i = 32'h300; rf_waddr_i = 5'd12;
        stall_n = 0; req_n = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (dmem_req_o) req_n++;
            if (!stall_o) break;
            stall_n++;
            next_cycle();
        end
        check("tmo_stall_cycles", stall_n, 16);
        check("tmo_req_cycles", req_n, 16);
        check("tmo_err_before", dmem_err_o, 1'b0);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        check("tmo_err_set", dmem_err_o, 1'b1);
        check("tmo_bubble", rf_we_o, 1'b0);
        check("tmo_stall_released", stall_o, 1'b0);
        check("tmo_no_reissue", dmem_req_o, 1'b0);
        next_cycle();
        alu_op(5'd1, 32'h0000_00AA);
        @(negedge clk);
        check("tmo_err_sticky", dmem_err_o, 1'b1);

        // Reset asserted while a load waits in RSP
        next_cycle();
        run_mem(1'b0, 32'h500, 32'h0, 5'd4, 0, 5, 32'h0, 1'b0, stall_n, req_n, taken_n) ;
        @(negedge clk);
        next_cycle();
        rf_we_i = 1'b1; mem2rf_i = 1'b1; alu_result_i = 32'h600; rf_waddr_i = 5'd6;
        dmem_gnt_i = 1'b1;
        begin
            exp_req_t r;
            r.we = 1'b0; r.addr = 32'h600; r.wdata = '0;
            exp_req.push_back(r);
        end
        next_cycle();
        dmem_gnt_i = 1'b0;
        #2 reset = 1'b0;
        @(negedge clk);
        check("rstmid_rf_we", rf_we_o, 1'b0);
        check("rstmid_waddr", rf_waddr_o, '0);
        check("rstmid_wdata", rf_wdata_o, '0);
        check("rstmid_err", dmem_err_o, 1'b0);
        clear_inputs();
        next_cycle();
        reset = 1'b1;
        next_cycle();
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555_5555;
        @(negedge clk);
        check("rstmid_stall", stall_o, 1'b0);
        check("rstmid_req", dmem_req_o, 1'b0);
        next_cycle();
        dmem_rvalid_i = 1'b0;
        @(negedge clk);
        check("rstmid_no_wb", rf_we_o, 1'b0);

        repeat (3) next_cycle();
        check("wb_queue_drained", exp_wb.size(), 0);
        check("req_queue_drained", exp_req.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
